// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream packet arbiter and its pickers.
// Pure definitions: no logic, no latency, no flow control.
// Imported by axis_rr_pick and axis_pkt_rr_arbiter.
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    localparam int PKT_CNT_W = 16;
    localparam int MAX_CH    = 16;

    // Out-of-range indices yield an all-zero vector.
    function automatic logic [MAX_CH-1:0] onehot(input int idx, input int n);
        logic [MAX_CH-1:0] v;
        v = '0;
        if (idx >= 0 && idx < n && idx < MAX_CH) begin
            v = MAX_CH'(1) << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Round-robin picker: first set req bit searching upward from ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module axis_rr_pick #(
    parameter int NUM_CH = 4,
    parameter int PTR_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [PTR_W-1:0]  gnt_idx,
    output logic              any_req
);

    // Scan from the farthest candidate down so the one nearest ptr wins last.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_idx = '0;
        any_req = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_CH;
            if (req[idx]) begin
                gnt_idx = PTR_W'(idx);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// NUM_CH:1 AXI-Stream packet arbiter, round-robin, grant locked until tlast; m_tid = source channel.
// Latency: accepted beat appears on m_* one cycle later; one bubble cycle per packet for grant.
// Backpressure: m_* hold while m_tvalid && !m_tready, s_tready is 0 then. AXIS_ARB_PKT_CNT_EN adds pkt_cnt.
module axis_pkt_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH-1:0]             s_tvalid,
    output logic [NUM_CH-1:0]             s_tready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]  s_tdata,
    input  logic [NUM_CH*DATA_WIDTH/8-1:0] s_tkeep,
    input  logic [NUM_CH-1:0]             s_tlast,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [DATA_WIDTH-1:0]         m_tdata,
    output logic [DATA_WIDTH/8-1:0]       m_tkeep,
    output logic                          m_tlast,
    output logic [ID_WIDTH-1:0]           m_tid,
    output logic [NUM_CH*PKT_CNT_W-1:0]   pkt_cnt
);

    localparam int PTR_W  = $clog2(NUM_CH);
    localparam int KEEP_W = DATA_WIDTH / 8;

    if (NUM_CH < 2 || NUM_CH > MAX_CH) begin : g_num_ch_chk
        $fatal(1, "axis_pkt_rr_arbiter: NUM_CH must be within 2..16");
    end
    if (ID_WIDTH < $clog2(NUM_CH)) begin : g_id_width_chk
        $fatal(1, "axis_pkt_rr_arbiter: ID_WIDTH too narrow for NUM_CH");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_data_width_chk
        $fatal(1, "axis_pkt_rr_arbiter: DATA_WIDTH must be a multiple of 8");
    end

    arb_state_e        state;
    logic [PTR_W-1:0]  grant;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  pick_idx;
    logic              any_req;
    logic              out_ready;
    logic              beat_acc;
    logic [MAX_CH-1:0] grant_oh;
    logic              unused_grant_oh;

    logic [DATA_WIDTH-1:0] sel_dat;
    logic [KEEP_W-1:0]     sel_keep;
    logic                  sel_last;

    axis_rr_pick #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_pick (
        .req     (s_tvalid),
        .ptr     (rr_ptr),
        .gnt_idx (pick_idx),
        .any_req (any_req)
    );

    assign out_ready       = !m_tvalid || m_tready;
    assign grant_oh        = onehot(int'(grant), NUM_CH);
    assign unused_grant_oh = ^grant_oh;
    assign s_tready        = (state == XFER && out_ready) ? grant_oh[NUM_CH-1:0] : '0;
    assign beat_acc        = (state == XFER) && out_ready && s_tvalid[grant];

    assign sel_dat  = s_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_keep = s_tkeep[int'(grant)*KEEP_W +: KEEP_W];
    assign sel_last = s_tlast[grant];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
            m_tid    <= '0;
        end else begin
            if (out_ready) begin
                if (beat_acc) begin
                    m_tvalid <= 1'b1;
                    m_tdata  <= sel_dat;
                    m_tkeep  <= sel_keep;
                    m_tlast  <= sel_last;
                    m_tid    <= ID_WIDTH'(grant);
                end else begin
                    m_tvalid <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant <= pick_idx;
                        state <= XFER;
                    end
                end
                XFER: begin
                    // Grant is held through tvalid gaps; only tlast releases it.
                    if (beat_acc && sel_last) begin
                        rr_ptr <= (grant == PTR_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXIS_ARB_PKT_CNT_EN
    logic [PKT_CNT_W-1:0] cnt_q [NUM_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (beat_acc && sel_last) begin
            cnt_q[grant] <= cnt_q[grant] + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt_out
        assign pkt_cnt[g*PKT_CNT_W +: PKT_CNT_W] = cnt_q[g];
    end
`else
    assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Directed self-checking bench for axis_pkt_rr_arbiter (NUM_CH=4, DATA_WIDTH=32, ID_WIDTH=2).
// Per-channel source tasks drive beats; a negedge monitor records every output handshake.
module tb_axis_pkt_rr_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   s_tvalid;
    logic [3:0]   s_tready;
    logic [127:0] s_tdata;
    logic [15:0]  s_tkeep;
    logic [3:0]   s_tlast;
    logic         m_tvalid;
    logic         m_tready;
    logic [31:0]  m_tdata;
    logic [3:0]   m_tkeep;
    logic         m_tlast;
    logic [1:0]   m_tid;
    logic [63:0]  pkt_cnt;

    logic        ch_vld [4];
    logic [31:0] ch_dat [4];
    logic        ch_lst [4];

    int checks;
    int failures;
    int cyc;

    typedef struct {
        int          tid;
        logic [31:0] d;
        logic        l;
        int          cyc;
    } beat_t;
    beat_t mon_q[$];

    axis_pkt_rr_arbiter #(
        .NUM_CH     (4),
        .DATA_WIDTH (32),
        .ID_WIDTH   (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tlast  (s_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .m_tid    (m_tid),
        .pkt_cnt  (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            s_tvalid[i]         = ch_vld[i];
            s_tdata[i*32 +: 32] = ch_dat[i];
            s_tlast[i]          = ch_lst[i];
        end
    end
    assign s_tkeep = 16'hFFFF;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && m_tvalid && m_tready)
                mon_q.push_back('{int'(m_tid), m_tdata, m_tlast, cyc});
        end
    end

    task automatic apply_reset();
        rst_n    = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ch_vld[i] = 1'b0;
            ch_dat[i] = '0;
            ch_lst[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input int ch, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (s_tvalid[ch] && s_tready[ch]) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
        end
    endtask

    // Sends one packet; after each accept the registered output must hold that beat.
    task automatic send_pkt(input int ch, input logic [31:0] base, input int nbeats,
                            input int gap_after, input int gap_len);
        bit ok;
        for (int b = 0; b < nbeats; b++) begin
            ch_vld[ch] = 1'b1;
            ch_dat[ch] = base + 32'(b);
            ch_lst[ch] = (b == nbeats - 1);
            wait_accept(ch, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL accept_timeout ch=%0d beat=%0d: no handshake within 200 cycles", ch, b);
                ch_vld[ch] = 1'b0;
                return;
            end
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== base + 32'(b) || m_tid !== 2'(ch)
                || m_tlast !== (b == nbeats - 1)) begin
                failures++;
                $display("FAIL out_after_accept ch=%0d beat=%0d: got vld=%b dat=%h tid=%0d last=%b, want vld=1 dat=%h tid=%0d last=%b",
                         ch, b, m_tvalid, m_tdata, m_tid, m_tlast, base + 32'(b), ch, (b == nbeats - 1));
            end
            if (b == gap_after) begin
                ch_vld[ch] = 1'b0;
                repeat (gap_len) @(posedge clk);
                #1;
            end
        end
        ch_vld[ch] = 1'b0;
        ch_lst[ch] = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (m_tvalid !== 1'b0 || m_tdata !== 32'h0 || m_tkeep !== 4'h0 || m_tlast !== 1'b0 || m_tid !== 2'd0) begin
            failures++;
            $display("FAIL reset_outputs: got vld=%b dat=%h keep=%h last=%b tid=%0d, want all 0",
                     m_tvalid, m_tdata, m_tkeep, m_tlast, m_tid);
        end
        checks++;
        if (s_tready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_s_tready: got %b want 0000", s_tready);
        end
        checks++;
        if (pkt_cnt !== 64'h0) begin
            failures++;
            $display("FAIL reset_pkt_cnt: got %h want 0", pkt_cnt);
        end
    endtask

    task automatic test_single_stream();
        mon_q.delete();
        m_tready = 1'b1;
        send_pkt(1, 32'hA0, 4, -1, 0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mon_q.size() != 4) begin
            failures++;
            $display("FAIL stream_count: got %0d beats want 4", mon_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (mon_q[i].tid != 1 || mon_q[i].d !== 32'hA0 + 32'(i) || mon_q[i].l !== (i == 3)
                    || mon_q[i].cyc != mon_q[0].cyc + i) begin
                    failures++;
                    $display("FAIL stream_beat%0d: got tid=%0d dat=%h last=%b cyc+%0d, want tid=1 dat=%h last=%b cyc+%0d",
                             i, mon_q[i].tid, mon_q[i].d, mon_q[i].l, mon_q[i].cyc - mon_q[0].cyc,
                             32'hA0 + 32'(i), (i == 3), i);
                end
            end
        end
        checks++;
        if (m_tkeep !== 4'hF) begin
            failures++;
            $display("FAIL stream_keep: got %h want f", m_tkeep);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        mon_q.delete();
        fork
            send_pkt(0, 32'hB0, 2, -1, 0);
            send_pkt(1, 32'hC0, 2, -1, 0);
            send_pkt(2, 32'hD0, 2, -1, 0);
            send_pkt(3, 32'hE0, 2, -1, 0);
        join
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mon_q.size() != 8) begin
            failures++;
            $display("FAIL rr_count: got %0d beats want 8", mon_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (mon_q[i].tid != i / 2 || mon_q[i].d !== 32'hB0 + 32'((i / 2) * 16 + (i % 2))) begin
                    failures++;
                    $display("FAIL rr_order%0d: got tid=%0d dat=%h, want tid=%0d dat=%h",
                             i, mon_q[i].tid, mon_q[i].d, i / 2, 32'hB0 + 32'((i / 2) * 16 + (i % 2)));
                end
            end
            for (int p = 1; p < 4; p++) begin
                checks++;
                if (mon_q[2*p].cyc - mon_q[2*p-1].cyc != 2) begin
                    failures++;
                    $display("FAIL rr_bubble%0d: got gap %0d want 2", p, mon_q[2*p].cyc - mon_q[2*p-1].cyc);
                end
            end
        end
        mon_q.delete();
        fork
            send_pkt(2, 32'h20, 1, -1, 0);
            send_pkt(0, 32'h10, 1, -1, 0);
        join
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mon_q.size() != 2 || mon_q[0].tid != 0 || mon_q[1].tid != 2) begin
            failures++;
            $display("FAIL rr_wrap: got %0d beats first_tid=%0d, want 2 beats order ch0 then ch2",
                     mon_q.size(), (mon_q.size() > 0) ? mon_q[0].tid : -1);
        end
    endtask

    task automatic test_backpressure();
        bit pat [8];
        logic [31:0] sd;
        logic        sl;
        logic [1:0]  sid;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        apply_reset();
        mon_q.delete();
        sd = '0; sl = 1'b0; sid = '0;
        fork
            send_pkt(2, 32'h50, 4, -1, 0);
            begin
                for (int t = 0; t < 100; t++) begin
                    if (m_tvalid) break;
                    @(posedge clk);
                    #1;
                end
                for (int k = 0; k < 8; k++) begin
                    m_tready = pat[k];
                    #1;
                    if (!pat[k]) begin
                        checks++;
                        if (s_tready[2] !== 1'b0) begin
                            failures++;
                            $display("FAIL bp_s_tready step%0d: got %b want 0", k, s_tready[2]);
                        end
                        sd = m_tdata; sl = m_tlast; sid = m_tid;
                    end
                    @(posedge clk);
                    #1;
                    if (!pat[k]) begin
                        checks++;
                        if (m_tvalid !== 1'b1 || m_tdata !== sd || m_tlast !== sl || m_tid !== sid) begin
                            failures++;
                            $display("FAIL bp_hold step%0d: got vld=%b dat=%h last=%b tid=%0d, want vld=1 dat=%h last=%b tid=%0d",
                                     k, m_tvalid, m_tdata, m_tlast, m_tid, sd, sl, sid);
                        end
                    end
                end
                m_tready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mon_q.size() != 4) begin
            failures++;
            $display("FAIL bp_count: got %0d beats want 4", mon_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (mon_q[i].tid != 2 || mon_q[i].d !== 32'h50 + 32'(i) || mon_q[i].l !== (i == 3)) begin
                    failures++;
                    $display("FAIL bp_beat%0d: got tid=%0d dat=%h last=%b, want tid=2 dat=%h last=%b",
                             i, mon_q[i].tid, mon_q[i].d, mon_q[i].l, 32'h50 + 32'(i), (i == 3));
                end
            end
        end
    endtask

    task automatic test_hold_grant();
        apply_reset();
        mon_q.delete();
        fork
            send_pkt(0, 32'h60, 4, 1, 5);
            begin
                for (int t = 0; t < 100; t++) begin
                    if (mon_q.size() > 0) break;
                    @(posedge clk);
                    #1;
                end
                send_pkt(3, 32'h70, 2, -1, 0);
            end
        join
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mon_q.size() != 6) begin
            failures++;
            $display("FAIL hold_count: got %0d beats want 6", mon_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (mon_q[i].tid != ((i < 4) ? 0 : 3)) begin
                    failures++;
                    $display("FAIL hold_order%0d: got tid=%0d want %0d", i, mon_q[i].tid, (i < 4) ? 0 : 3);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        apply_reset();
        send_pkt(2, 32'h80, 1, -1, 0);
        ch_vld[0] = 1'b1;
        for (int b = 0; b < 2; b++) begin
            ch_dat[0] = 32'h90 + 32'(b);
            ch_lst[0] = 1'b0;
            wait_accept(0, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL rmid_accept beat=%0d: no handshake within 200 cycles", b);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== 4'b0000) begin
            failures++;
            $display("FAIL rmid_async: got m_tvalid=%b s_tready=%b, want 0 and 0000", m_tvalid, s_tready);
        end
        ch_vld[0] = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_q.delete();
        fork
            send_pkt(3, 32'hF0, 1, -1, 0);
            send_pkt(0, 32'h30, 2, -1, 0);
        join
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mon_q.size() != 3 || mon_q[0].tid != 0 || mon_q[0].d !== 32'h30 || mon_q[2].tid != 3) begin
            failures++;
            $display("FAIL rmid_recover: got %0d beats first_tid=%0d, want 3 beats ch0 (0x30,0x31) then ch3",
                     mon_q.size(), (mon_q.size() > 0) ? mon_q[0].tid : -1);
        end
    endtask

    task automatic test_pkt_cnt();
`ifdef AXIS_ARB_PKT_CNT_EN
        apply_reset();
        for (int p = 0; p < 5; p++) send_pkt(1, 32'h40, 1, -1, 0);
        send_pkt(3, 32'h44, 2, -1, 0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (pkt_cnt !== {16'd1, 16'd0, 16'd5, 16'd0}) begin
            failures++;
            $display("FAIL pkt_cnt_en: got %h want %h", pkt_cnt, {16'd1, 16'd0, 16'd5, 16'd0});
        end
`else
        send_pkt(1, 32'h40, 1, -1, 0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (pkt_cnt !== 64'h0) begin
            failures++;
            $display("FAIL pkt_cnt_dis: got %h want 0", pkt_cnt);
        end
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ch_vld[i] = 1'b0;
            ch_dat[i] = '0;
            ch_lst[i] = 1'b0;
        end
        test_reset();
        test_single_stream();
        test_round_robin();
        test_backpressure();
        test_hold_grant();
        test_reset_mid();
        test_pkt_cnt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
